// File: rtl/apb_intercon_rr.sv
// apb_intercon_rr: round-robin N-master to M-slave shared APB bus; define APB_INTERCON_TIMEOUT_EN for an ACCESS timeout.
module apb_intercon_rr #(
  parameter int MASTER_PORTS   = 4,
  parameter int SLAVE_PORTS    = 8,
  parameter int BUS_WIDTH      = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int SEL_BITS       = 4,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int GW = MASTER_PORTS > 1 ? $clog2(MASTER_PORTS) : 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0]  S_PADDR,
  input  logic [MASTER_PORTS-1:0]            S_PWRITE,
  input  logic [MASTER_PORTS-1:0]            S_PSELx,
  input  logic [MASTER_PORTS-1:0]            S_PENABLE,
  input  logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PWDATA,
  output logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PRDATA,
  output logic [MASTER_PORTS-1:0]            S_PREADY,
  output logic [MASTER_PORTS-1:0]            S_PSLVERR,
  output logic [BUS_WIDTH-1:0]               M_PADDR,
  output logic                               M_PWRITE,
  output logic [SLAVE_PORTS-1:0]             M_PSELx,
  output logic                               M_PENABLE,
  output logic [DATA_WIDTH-1:0]              M_PWDATA,
  input  logic [SLAVE_PORTS*DATA_WIDTH-1:0]  M_PRDATA,
  input  logic [SLAVE_PORTS-1:0]             M_PREADY,
  output logic [GW-1:0]                      grant_id,
  output logic                               busy
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state;
  logic [GW-1:0] ptr, nxt;
  logic [BUS_WIDTH-1:0] req_addr;
  logic [SEL_BITS-1:0] req_idx;
  logic [DATA_WIDTH-1:0] rdata;
  logic [MASTER_PORTS-1:0] gmask;
  logic rdy;
  logic unused_ok;
`ifdef APB_INTERCON_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] cnt;
`endif
  assign unused_ok = ^{S_PENABLE, TIMEOUT_CYCLES > 0};
  // search downward so the closest requester after ptr is the last (winning) assignment
  always_comb begin
    nxt = ptr;
    for (int i = MASTER_PORTS; i >= 1; i--)
      if (S_PSELx[(int'(ptr) + i) % MASTER_PORTS]) nxt = GW'((int'(ptr) + i) % MASTER_PORTS);
  end
  assign req_addr = S_PADDR[nxt*BUS_WIDTH +: BUS_WIDTH];
  assign req_idx  = req_addr[BUS_WIDTH-1 -: SEL_BITS];
  assign gmask    = MASTER_PORTS'(1) << grant_id;
  // M_PSELx is one-hot during ACCESS, so it doubles as the slave mux select
  assign rdy      = |(M_PREADY & M_PSELx);
  always_comb begin
    rdata = '0;
    for (int s = 0; s < SLAVE_PORTS; s++)
      rdata = rdata | (M_PRDATA[s*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{M_PSELx[s]}});
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= GW'(MASTER_PORTS - 1);
      grant_id  <= '0;
      busy      <= 1'b0;
      S_PRDATA  <= '0;
      S_PREADY  <= '0;
      S_PSLVERR <= '0;
      M_PADDR   <= '0;
      M_PWRITE  <= 1'b0;
      M_PSELx   <= '0;
      M_PENABLE <= 1'b0;
      M_PWDATA  <= '0;
`ifdef APB_INTERCON_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (|S_PSELx) begin
          state    <= SETUP;
          busy     <= 1'b1;
          grant_id <= nxt;
          M_PADDR  <= req_addr;
          M_PWRITE <= S_PWRITE[nxt];
          M_PWDATA <= S_PWDATA[nxt*DATA_WIDTH +: DATA_WIDTH];
          M_PSELx  <= int'(req_idx) < SLAVE_PORTS ? SLAVE_PORTS'(1) << req_idx : '0;
        end
        SETUP: if (|M_PSELx) begin
          state     <= ACCESS;
          M_PENABLE <= 1'b1;
`ifdef APB_INTERCON_TIMEOUT_EN
          cnt       <= '0;
`endif
        end else begin
          state     <= RESP;
          S_PREADY  <= gmask;
          S_PSLVERR <= gmask;
        end
        ACCESS: if (rdy) begin
          state     <= RESP;
          M_PSELx   <= '0;
          M_PENABLE <= 1'b0;
          S_PREADY  <= gmask;
          S_PRDATA[grant_id*DATA_WIDTH +: DATA_WIDTH] <= rdata;
        end
`ifdef APB_INTERCON_TIMEOUT_EN
        else if (cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state     <= RESP;
          M_PSELx   <= '0;
          M_PENABLE <= 1'b0;
          S_PREADY  <= gmask;
          S_PSLVERR <= gmask;
        end else cnt <= cnt + 1'b1;
`endif
        RESP: begin
          state     <= IDLE;
          busy      <= 1'b0;
          ptr       <= grant_id;
          S_PREADY  <= '0;
          S_PSLVERR <= '0;
          S_PRDATA  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_intercon_rr.sv
// tb_apb_intercon_rr: directed vector table plus hand-written round-robin, reset and hang sequences.
module tb_apb_intercon_rr;
  localparam int M = 4, S = 8, W = 16;
  logic clk = 1'b0, reset = 1'b0;
  logic [M*W-1:0] S_PADDR, S_PWDATA, S_PRDATA;
  logic [M-1:0] S_PWRITE, S_PSELx, S_PENABLE, S_PREADY, S_PSLVERR;
  logic [W-1:0] M_PADDR, M_PWDATA;
  logic M_PWRITE, M_PENABLE, busy;
  logic [S-1:0] M_PSELx, M_PREADY;
  logic [S*W-1:0] M_PRDATA;
  logic [1:0] grant_id;
  int n_tests = 0, n_fail = 0;

  apb_intercon_rr #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .S_PADDR(S_PADDR), .S_PWRITE(S_PWRITE), .S_PSELx(S_PSELx), .S_PENABLE(S_PENABLE),
    .S_PWDATA(S_PWDATA), .S_PRDATA(S_PRDATA), .S_PREADY(S_PREADY), .S_PSLVERR(S_PSLVERR),
    .M_PADDR(M_PADDR), .M_PWRITE(M_PWRITE), .M_PSELx(M_PSELx), .M_PENABLE(M_PENABLE),
    .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int m; logic [15:0] addr; logic wr; logic [15:0] wdata; logic [15:0] srd; int waits;
    logic [7:0] sel; logic [15:0] rd; logic err; int lat; int en;
  } vec_t;
  vec_t tbl[6];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int lat = 0, en = 0;
    logic [63:0] ev;
    for (int s = 0; s < S; s++) M_PRDATA[s*W +: W] = v.sel[s] ? v.srd : 16'hD000 + 16'(s);
    S_PADDR[v.m*W +: W] = v.addr;
    S_PWDATA[v.m*W +: W] = v.wdata;
    S_PWRITE[v.m] = v.wr;
    S_PSELx[v.m] = 1'b1;
    M_PREADY = '0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      tick;
      if (c == 1) begin
        chk("setup_psel", M_PSELx, v.sel);
        chk("setup_penable", M_PENABLE, 0);
        chk("setup_paddr", M_PADDR, v.addr);
        chk("setup_pwrite", M_PWRITE, v.wr);
        chk("setup_pwdata", M_PWDATA, v.wdata);
        chk("setup_grant", grant_id, v.m);
        chk("setup_busy", busy, 1);
      end
      if (M_PENABLE) begin
        en++;
        M_PREADY = (en > v.waits) ? v.sel : '0;
      end
      if (S_PREADY != 0) begin
        lat = c;
        ev = '0;
        ev[v.m*W +: W] = v.rd;
        chk("resp_pready", S_PREADY, 4'b0001 << v.m);
        chk("resp_pslverr", S_PSLVERR, v.err ? 4'b0001 << v.m : 4'b0000);
        chk("resp_prdata", S_PRDATA, ev);
        chk("resp_psel", M_PSELx, 0);
        chk("resp_penable", M_PENABLE, 0);
        S_PSELx[v.m] = 1'b0;
        M_PREADY = '0;
      end
    end
    chk("latency", lat, v.lat);
    chk("enable_cycles", en, v.en);
    tick;
    chk("pulse_end", S_PREADY, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k, lat;
    int order[5];
    logic [63:0] ev;
    tbl[0] = '{0, 16'h1004, 1'b0, 16'h0000, 16'hBEEF, 0, 8'h02, 16'hBEEF, 1'b0, 3, 1};
    tbl[1] = '{2, 16'h3000, 1'b1, 16'h00AA, 16'h1234, 5, 8'h08, 16'h1234, 1'b0, 8, 6};
    tbl[2] = '{1, 16'hF000, 1'b0, 16'h0000, 16'h7777, 0, 8'h00, 16'h0000, 1'b1, 2, 0};
    tbl[3] = '{3, 16'h7FFE, 1'b0, 16'h0000, 16'hA5A5, 2, 8'h80, 16'hA5A5, 1'b0, 5, 3};
    tbl[4] = '{1, 16'h8000, 1'b1, 16'h1111, 16'h2222, 0, 8'h00, 16'h0000, 1'b1, 2, 0};
    tbl[5] = '{0, 16'h0010, 1'b1, 16'h5A5A, 16'h0F0F, 1, 8'h01, 16'h0F0F, 1'b0, 4, 2};
    order = '{0, 1, 2, 3, 0};
    S_PADDR = '0; S_PWDATA = '0; S_PWRITE = '0; S_PSELx = '0; S_PENABLE = '0;
    M_PRDATA = '0; M_PREADY = '0;
    repeat (2) tick;
    chk("rst_psel", M_PSELx, 0);
    chk("rst_penable", M_PENABLE, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pready", S_PREADY, 0);
    chk("rst_pslverr", S_PSLVERR, 0);
    chk("rst_prdata", S_PRDATA, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_paddr", M_PADDR, 0);
    reset = 1'b1;
    tick;
    for (int i = 0; i < 6; i++) run_txn(tbl[i]);

    // all four masters hold their requests: rotating service 0,1,2,3,0
    reset = 1'b0;
    tick;
    reset = 1'b1;
    for (int m = 0; m < M; m++) S_PADDR[m*W +: W] = 16'(m * 16'h1000 + m);
    for (int s = 0; s < S; s++) M_PRDATA[s*W +: W] = 16'h0100 + 16'(s);
    S_PWRITE = '0;
    M_PREADY = '1;
    S_PSELx = '1;
    k = 0;
    for (int c = 0; c < 60 && k < 5; c++) begin
      tick;
      if (S_PREADY != 0) begin
        ev = '0;
        ev[order[k]*W +: W] = 16'h0100 + 16'(order[k]);
        chk("rr_pready", S_PREADY, 4'b0001 << order[k]);
        chk("rr_grant", grant_id, order[k]);
        chk("rr_prdata", S_PRDATA, ev);
        k++;
        if (k == 5) S_PSELx = '0;
        tick;
        chk("rr_pulse_end", S_PREADY, 0);
      end
    end
    chk("rr_count", k, 5);
    tick;

    // asynchronous reset in the middle of ACCESS
    M_PREADY = '0;
    S_PADDR[0 +: W] = 16'h2000;
    S_PSELx = 4'b0001;
    tick;
    tick;
    chk("acc_penable", M_PENABLE, 1);
    chk("acc_psel", M_PSELx, 8'h04);
    #2 reset = 1'b0;
    #1;
    chk("arst_psel", M_PSELx, 0);
    chk("arst_penable", M_PENABLE, 0);
    chk("arst_busy", busy, 0);
    S_PSELx = 4'b0011;
    M_PREADY = '1;
    tick;
    chk("arst_no_pready", S_PREADY, 0);
    reset = 1'b1;
    tick;
    chk("post_rst_grant", grant_id, 0);
    chk("post_rst_psel", M_PSELx, 8'h04);
    k = 0;
    for (int c = 0; c < 30 && k < 2; c++) begin
      tick;
      if (S_PREADY != 0) begin
        chk("post_rst_order", grant_id, k);
        S_PSELx[k] = 1'b0;
        k++;
      end
    end
    chk("post_rst_count", k, 2);
    tick;

    // slave never ready
    M_PREADY = '0;
    S_PADDR[0 +: W] = 16'h2000;
    S_PSELx = 4'b0001;
    lat = 0;
    for (int c = 1; c <= 30 && lat == 0; c++) begin
      tick;
      if (S_PREADY != 0) begin
        lat = c;
        chk("to_pslverr", S_PSLVERR, 4'b0001);
        chk("to_prdata", S_PRDATA, 0);
        chk("to_psel", M_PSELx, 0);
        S_PSELx = '0;
      end
    end
`ifdef APB_INTERCON_TIMEOUT_EN
    chk("to_latency", lat, 6);
    tick;
    chk("to_busy", busy, 0);
`else
    chk("hang_latency", lat, 0);
    chk("hang_busy", busy, 1);
    chk("hang_penable", M_PENABLE, 1);
    S_PSELx = '0;
    reset = 1'b0;
    tick;
    reset = 1'b1;
`endif
    tick;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
